dds_sweep_controller: RTL and testbench
=======================================

Name: dds_sweep_controller

Overview:
Sequencer that drives the 32-bit DDS frequency control word (Step) over time, producing linear frequency sweeps for the SinWave/TriangularWave/PWMWave generators. It sits between the button/config logic and the wave generators as an alternative source of Step, muxed in upstream. It supports single, repeating-sawtooth and ping-pong sweeps with a programmable dwell per frequency point.

Parameters:
WORD_W, 32, width of the frequency control word
DWELL_W, 24, width of the dwell counter (clk cycles per sweep point)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  stop sweep immediately
mode  input  2  00 single, 01 sawtooth repeat, 10 ping-pong, 11 treated as 00
start_word  input  WORD_W  first frequency word
stop_word  input  WORD_W  final frequency word
delta_word  input  WORD_W  increment magnitude per point
dwell_cycles  input  DWELL_W  cycles each point is held; 0 treated as 1
step_out  output  WORD_W  frequency control word to the wave generators
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at end of single sweep
sweep_dir  output  1  1 = rising frequency, 0 = falling
cfg_err  output  1  one-cycle pulse: start rejected (delta_word == 0)

Behaviour:
- One clock; reset synchronous, active-high. Reset: step_out=0, busy=0, done=0, sweep_dir=0, cfg_err=0, FSM to IDLE; applies mid-sweep with same result.
- FSM states: IDLE, DWELL, DONE.
- IDLE: start=1 at cycle N -> latch start/stop/delta/dwell/mode. If latched delta==0: cfg_err=1 at N+1, stay IDLE, step_out unchanged. Else at N+1: step_out=start_word, busy=1, sweep_dir=(stop_word>=start_word), dwell counter loaded with max(dwell,1), go DWELL.
- Inputs other than abort/reset ignored while busy; start while busy ignored. Config changes take effect only at next start.
- DWELL: each point held exactly D=max(dwell,1) cycles. At end of dwell:
  - if step_out != leg end: next = step_out +/- delta, computed in WORD_W+1 bits; if next passes or equals leg end (incl. overflow/underflow), step_out = leg end (clamp, never overshoot).
  - if step_out == leg end: end of leg. mode 00 -> DONE. mode 01 -> step_out=start_word, new leg. mode 10 -> swap leg endpoints, toggle sweep_dir, step toward the new end by delta (clamped).
- DONE: one cycle; done=1, busy=0, step_out holds stop_word; then IDLE.
- abort: priority over all but reset; next cycle FSM IDLE, busy=0, step_out holds current value, done not pulsed. Abort and start same cycle in IDLE: abort wins, no start.
- start_word==stop_word: holds word for D cycles then leg end (mode 00 done; 01/10 repeat holding same word).
- Single sweep duration: ceil(|stop-start|/delta)+1 points x D cycles, done on the following cycle.
- All outputs registered; no combinational input->output paths.

Decomposition:
- Shared package dds_pkg: WORD_W default, mode encodings (MODE_SINGLE, MODE_SAW, MODE_PINGPONG), FSM state enum.
- One natural sub-module: sweep_step_calc (combinational clamped add/sub toward target, WORD_W+1 internal), reused for both directions.

Test Plan:
- Up single: start=100, stop=130, delta=10, dwell=3, mode 00 -> step_out 100,110,120,130 each for 3 cycles; done pulse 1 cycle after last 130 cycle; busy low thereafter, step_out stays 130.
- Clamp: start=100, stop=125, delta=10, dwell=1 -> 100,110,120,125, done; down sweep 200->170 delta 10 -> 200,190,180,170, sweep_dir=0.
- Overflow clamp: start=0xFFFFFFF0, stop=0xFFFFFFFF, delta=0x20 -> 0xFFFFFFF0 then 0xFFFFFFFF, no wrap to small value.
- Ping-pong: 10->30 delta 10 dwell 2 mode 10 -> 10,20,30,20,10,20,... sweep_dir toggles at 30 and 10; sawtooth mode 01 -> 10,20,30,10,20,...
- Abort at third point of 100->130 sweep -> next cycle busy=0, step_out=120 held, no done; delta_word=0 start -> cfg_err pulse, busy stays 0.
- Reset asserted mid-sweep -> next cycle step_out=0, busy=0, sweep_dir=0; start during busy ignored (sequence unchanged); dwell=0 behaves as dwell=1.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency sweep sequencer: default widths,
// sweep mode encodings and the sequencer state type.
package dds_pkg;

    localparam int DEFAULT_WORD_W  = 32;
    localparam int DEFAULT_DWELL_W = 24;

    typedef enum logic [1:0] {
        MODE_SINGLE   = 2'b00,
        MODE_SAW      = 2'b01,
        MODE_PINGPONG = 2'b10
    } sweepModeT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DWELL = 2'b01,
        ST_DONE  = 2'b10
    } sweepStateT;

    // The unused encoding 2'b11 behaves as a single sweep.
    function automatic sweepModeT normalizeMode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_SAW;
            2'b10:   return MODE_PINGPONG;
            default: return MODE_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/sweep_step_calc.sv
// Moves a frequency word one delta toward a target, clamping to the target
// instead of overshooting it or wrapping around the word range.
module sweep_step_calc #(
    parameter int W = 32
) (
    input  logic [W-1:0] current,
    input  logic [W-1:0] delta,
    input  logic [W-1:0] target,
    input  logic         up,
    output logic [W-1:0] nextWord
);

    logic [W:0] sumWide;
    logic [W:0] diffWide;
    logic       overshootUp;
    logic       overshootDown;

    // One extra bit so a carry out or borrow is visible as a pass of the target.
    assign sumWide  = {1'b0, current} + {1'b0, delta};
    assign diffWide = {1'b0, current} - {1'b0, delta};

    assign overshootUp   = (sumWide >= {1'b0, target});
    assign overshootDown = diffWide[W] || (diffWide[W-1:0] <= target);

    always_comb begin
        nextWord = current;
        if (up) begin
            nextWord = overshootUp ? target : sumWide[W-1:0];
        end else begin
            nextWord = overshootDown ? target : diffWide[W-1:0];
        end
    end

endmodule

// File: rtl/dds_sweep_controller.sv
// Linear frequency sweep sequencer producing the DDS step word: single,
// repeating sawtooth and ping-pong sweeps with a programmable dwell per point.
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int WORD_W  = DEFAULT_WORD_W,
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [WORD_W-1:0]  start_word,
    input  logic [WORD_W-1:0]  stop_word,
    input  logic [WORD_W-1:0]  delta_word,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [WORD_W-1:0]  step_out,
    output logic               busy,
    output logic               done,
    output logic               sweep_dir,
    output logic               cfg_err
);

    sweepStateT         stateReg;
    sweepModeT          modeReg;
    logic [WORD_W-1:0]  stepReg;
    logic [WORD_W-1:0]  legStartReg;
    logic [WORD_W-1:0]  legEndReg;
    logic [WORD_W-1:0]  deltaReg;
    logic [DWELL_W-1:0] dwellLoadReg;
    logic [DWELL_W-1:0] dwellCntReg;
    logic               busyReg;
    logic               doneReg;
    logic               dirReg;
    logic               cfgErrReg;

    logic [DWELL_W-1:0] dwellLoad;
    logic               atLegEnd;
    logic [WORD_W-1:0]  calcTarget;
    logic               calcUp;
    logic [WORD_W-1:0]  calcWord;

    // Counter reloads with D-1 so a point is held for D cycles; 0 acts like 1.
    assign dwellLoad = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);

    assign atLegEnd = (stepReg == legEndReg);

    // At a ping-pong leg end the next point heads back toward the old leg start.
    assign calcTarget = atLegEnd ? legStartReg : legEndReg;
    assign calcUp     = atLegEnd ? ~dirReg : dirReg;

    sweep_step_calc #(
        .W(WORD_W)
    ) stepCalc (
        .current  (stepReg),
        .delta    (deltaReg),
        .target   (calcTarget),
        .up       (calcUp),
        .nextWord (calcWord)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= ST_IDLE;
            modeReg      <= MODE_SINGLE;
            stepReg      <= '0;
            legStartReg  <= '0;
            legEndReg    <= '0;
            deltaReg     <= '0;
            dwellLoadReg <= '0;
            dwellCntReg  <= '0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            dirReg       <= 1'b0;
            cfgErrReg    <= 1'b0;
        end else begin
            doneReg   <= 1'b0;
            cfgErrReg <= 1'b0;

            if (abort) begin
                stateReg <= ST_IDLE;
                busyReg  <= 1'b0;
            end else begin
                case (stateReg)
                    ST_IDLE: begin
                        if (start) begin
                            if (delta_word == '0) begin
                                cfgErrReg <= 1'b1;
                            end else begin
                                modeReg      <= normalizeMode(mode);
                                legStartReg  <= start_word;
                                legEndReg    <= stop_word;
                                deltaReg     <= delta_word;
                                dwellLoadReg <= dwellLoad;
                                dwellCntReg  <= dwellLoad;
                                stepReg      <= start_word;
                                dirReg       <= (stop_word >= start_word);
                                busyReg      <= 1'b1;
                                stateReg     <= ST_DWELL;
                            end
                        end
                    end

                    ST_DWELL: begin
                        if (dwellCntReg != '0) begin
                            dwellCntReg <= dwellCntReg - DWELL_W'(1);
                        end else begin
                            dwellCntReg <= dwellLoadReg;
                            if (!atLegEnd) begin
                                stepReg <= calcWord;
                            end else begin
                                case (modeReg)
                                    MODE_SAW: begin
                                        stepReg <= legStartReg;
                                    end
                                    MODE_PINGPONG: begin
                                        legStartReg <= legEndReg;
                                        legEndReg   <= legStartReg;
                                        dirReg      <= ~dirReg;
                                        stepReg     <= calcWord;
                                    end
                                    default: begin
                                        stateReg <= ST_DONE;
                                        busyReg  <= 1'b0;
                                        doneReg  <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_DONE: begin
                        stateReg <= ST_IDLE;
                    end

                    default: begin
                        stateReg <= ST_IDLE;
                        busyReg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step_out  = stepReg;
    assign busy      = busyReg;
    assign done      = doneReg;
    assign sweep_dir = dirReg;
    assign cfg_err   = cfgErrReg;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: directed and random sweeps compared per cycle
// against a point-list model built from plain 64-bit arithmetic.
module tb_dds_sweep_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [31:0] start_word;
    logic [31:0] stop_word;
    logic [31:0] delta_word;
    logic [23:0] dwell_cycles;
    logic [31:0] step_out;
    logic        busy;
    logic        done;
    logic        sweep_dir;
    logic        cfg_err;

    int          numChecks = 0;
    int          numFails  = 0;
    longint      heldWord  = 0;
    longint      expWord[$];
    bit          expDir[$];

    dds_sweep_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .start_word   (start_word),
        .stop_word    (stop_word),
        .delta_word   (delta_word),
        .dwell_cycles (dwell_cycles),
        .step_out     (step_out),
        .busy         (busy),
        .done         (done),
        .sweep_dir    (sweep_dir),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        numChecks++;
        if (got !== want) begin
            numFails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic longint stepToward(longint cur, longint tgt, longint d);
        if (tgt >= cur) return (cur + d >= tgt) ? tgt : cur + d;
        return (cur - d <= tgt) ? tgt : cur - d;
    endfunction

    // Ordered list of frequency points the sweep visits, up to 'limit' points.
    task automatic buildPoints(longint s, longint e, longint d, int m, int limit);
        longint cur;
        longint legA;
        longint legB;
        longint tmp;
        bit     dir;
        cur  = s;
        legA = s;
        legB = e;
        dir  = (e >= s);
        expWord.delete();
        expDir.delete();
        while (expWord.size() < limit) begin
            expWord.push_back(cur);
            expDir.push_back(dir);
            if (cur != legB) begin
                cur = stepToward(cur, legB, d);
            end else if (m == 1) begin
                cur = s;
            end else if (m == 2) begin
                tmp  = legA;
                legA = legB;
                legB = tmp;
                dir  = !dir;
                cur  = stepToward(cur, legB, d);
            end else begin
                break;
            end
        end
    endtask

    task automatic runSweep(input string name, input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] d, input logic [23:0] dw, input logic [1:0] m,
                            input int abortAt, input bit noise);
        int dCyc;
        dCyc = (dw == 0) ? 1 : int'(dw);
        buildPoints(longint'(s), longint'(e), longint'(d), int'(m), abortAt + 1);
        start_word   = s;
        stop_word    = e;
        delta_word   = d;
        dwell_cycles = dw;
        mode         = m;
        start        = 1'b1;
        tick();
        start = 1'b0;
        $display("sweep %s: %0h -> %0h delta %0h dwell %0d mode %0d, %0d points",
                 name, s, e, d, dw, m, expWord.size());
        for (int i = 0; i < expWord.size(); i++) begin
            if (i == abortAt) begin
                expectEq({name, ":preabort_step"}, step_out, 32'(expWord[i]));
                start = 1'b0;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                expectEq({name, ":abort_busy"}, 32'(busy), 32'd0);
                expectEq({name, ":abort_done"}, 32'(done), 32'd0);
                expectEq({name, ":abort_step"}, step_out, 32'(expWord[i]));
                tick();
                expectEq({name, ":idle_busy"}, 32'(busy), 32'd0);
                expectEq({name, ":idle_step"}, step_out, 32'(expWord[i]));
                heldWord = expWord[i];
                return;
            end
            for (int c = 0; c < dCyc; c++) begin
                expectEq({name, ":step"}, step_out, 32'(expWord[i]));
                expectEq({name, ":busy"}, 32'(busy), 32'd1);
                expectEq({name, ":dir"}, 32'(sweep_dir), 32'(expDir[i]));
                expectEq({name, ":done"}, 32'(done), 32'd0);
                if (noise) begin
                    start        = 1'($urandom);
                    start_word   = $urandom;
                    stop_word    = $urandom;
                    delta_word   = $urandom;
                    dwell_cycles = 24'($urandom);
                    mode         = 2'($urandom);
                end
                tick();
            end
        end
        start = 1'b0;
        expectEq({name, ":done_pulse"}, 32'(done), 32'd1);
        expectEq({name, ":done_busy"}, 32'(busy), 32'd0);
        expectEq({name, ":done_step"}, step_out, e);
        tick();
        expectEq({name, ":after_done"}, 32'(done), 32'd0);
        expectEq({name, ":after_busy"}, 32'(busy), 32'd0);
        expectEq({name, ":after_step"}, step_out, e);
        heldWord = longint'(e);
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] re;
        longint      span;
        longint      dl;
        logic [1:0]  rm;
        int          ra;

        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        mode         = 2'b00;
        start_word   = '0;
        stop_word    = '0;
        delta_word   = '0;
        dwell_cycles = '0;
        repeat (3) tick();
        expectEq("reset_step", step_out, 32'd0);
        expectEq("reset_busy", 32'(busy), 32'd0);
        expectEq("reset_done", 32'(done), 32'd0);
        expectEq("reset_dir", 32'(sweep_dir), 32'd0);
        expectEq("reset_cfgerr", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        tick();

        runSweep("up", 32'd100, 32'd130, 32'd10, 24'd3, 2'b00, 1000, 1'b0);
        runSweep("clamp", 32'd100, 32'd125, 32'd10, 24'd1, 2'b00, 1000, 1'b0);
        runSweep("down", 32'd200, 32'd170, 32'd10, 24'd1, 2'b00, 1000, 1'b0);
        runSweep("ovf", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd1, 2'b00, 1000, 1'b0);
        runSweep("unf", 32'h10, 32'h0, 32'h30, 24'd2, 2'b11, 1000, 1'b0);
        runSweep("pingpong", 32'd10, 32'd30, 32'd10, 24'd2, 2'b10, 9, 1'b0);
        runSweep("saw", 32'd10, 32'd30, 32'd10, 24'd2, 2'b01, 8, 1'b0);
        runSweep("abort3", 32'd100, 32'd130, 32'd10, 24'd3, 2'b00, 2, 1'b0);
        runSweep("dwell0", 32'd5, 32'd8, 32'd1, 24'd0, 2'b11, 1000, 1'b1);
        runSweep("equal", 32'd42, 32'd42, 32'd5, 24'd2, 2'b00, 1000, 1'b0);
        runSweep("equal_pp", 32'd42, 32'd42, 32'd5, 24'd2, 2'b10, 4, 1'b0);

        // Zero delta is rejected with a one-cycle error pulse.
        start_word = 32'd777;
        stop_word  = 32'd999;
        delta_word = 32'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        $display("cfg_err: zero delta start");
        expectEq("cfgerr_pulse", 32'(cfg_err), 32'd1);
        expectEq("cfgerr_busy", 32'(busy), 32'd0);
        expectEq("cfgerr_step", step_out, 32'(heldWord));
        tick();
        expectEq("cfgerr_clear", 32'(cfg_err), 32'd0);
        expectEq("cfgerr_idle", 32'(busy), 32'd0);

        // Abort beats a simultaneous start.
        delta_word = 32'd5;
        start      = 1'b1;
        abort      = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        $display("start+abort same cycle");
        expectEq("startabort_busy", 32'(busy), 32'd0);
        expectEq("startabort_step", step_out, 32'(heldWord));
        expectEq("startabort_cfgerr", 32'(cfg_err), 32'd0);
        tick();
        expectEq("startabort_idle", 32'(busy), 32'd0);

        // Reset in the middle of a sweep.
        start_word   = 32'd500;
        stop_word    = 32'd900;
        delta_word   = 32'd7;
        dwell_cycles = 24'd2;
        mode         = 2'b00;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        $display("reset mid-sweep");
        expectEq("midreset_step", step_out, 32'd0);
        expectEq("midreset_busy", 32'(busy), 32'd0);
        expectEq("midreset_dir", 32'(sweep_dir), 32'd0);
        expectEq("midreset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        expectEq("postreset_busy", 32'(busy), 32'd0);
        expectEq("postreset_step", step_out, 32'd0);
        heldWord = 0;

        for (int n = 0; n < 40; n++) begin
            rs = $urandom;
            re = $urandom;
            if ($urandom_range(0, 7) == 0) re = rs;
            if ($urandom_range(0, 5) == 0) rs = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
            span = (re >= rs) ? longint'(re) - longint'(rs) : longint'(rs) - longint'(re);
            dl   = span / longint'($urandom_range(1, 12)) + longint'($urandom_range(1, 4));
            if (dl > 64'sh0000_0000_FFFF_FFFF) dl = 64'sh0000_0000_FFFF_FFFF;
            rm = 2'($urandom_range(0, 3));
            if (rm == 2'b01 || rm == 2'b10) ra = int'($urandom_range(1, 30));
            else ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 1000;
            runSweep($sformatf("rnd%0d", n), rs, re, 32'(dl), 24'($urandom_range(0, 3)), rm, ra, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
